gift_rect_drawer: RTL and testbench
===================================

Name: gift_rect_drawer

Overview:
Rectangle raster engine for the falling-gifts game. It sits directly upstream of the VGA adapter and drives its pixel-write interface (VGA_X, VGA_Y, VGA_COLOR, plot) at one pixel per clock. The game-control FSM issues one draw or erase command per object per frame through a start/busy/done handshake. Pixels that fall off-screen are clipped.

Parameters:
RESOLUTION, "160x120", screen size; legal values "640x480", "320x240", "160x120"
n, 8, X width: 10 / 9 / 8 for 640 / 320 / 160 resolution; Y width is n-1
XSCREEN, 160, visible width; derived from RESOLUTION
YSCREEN, 120, visible height; derived from RESOLUTION

Ports:
CLOCK_50  in  1  system clock; all logic on the rising edge
Reset  in  1  synchronous, active-high
start  in  1  command strobe; accepted only when busy=0
x0  in  n  rectangle left column
y0  in  n-1  rectangle top row
w  in  n  width in pixels
h  in  n-1  height in pixels
color  in  24  fill colour
erase  in  1  1 = fill with bg_color instead of color
bg_color  in  24  background colour
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse when the command finishes
VGA_X  out  n  pixel column
VGA_Y  out  n-1  pixel row
VGA_COLOR  out  24  pixel colour
plot  out  1  write-enable to the VGA adapter

Behaviour:
- Reset (synchronous, takes priority over everything): state=IDLE; busy, done, plot = 0; VGA_X, VGA_Y, VGA_COLOR = 0.
- FSM states: IDLE, DRAW, FINISH.
- IDLE:
  - start=1 latches x0, y0, w, h and the fill colour (erase ? bg_color : color).
  - Clears counters dx and dy to 0.
  - Goes to DRAW, or straight to FINISH if w==0 or h==0.
- Commands are latched, so input changes after acceptance have no effect.
- start while busy=1 is ignored. It is not queued.
- DRAW, every cycle:
  - Registered outputs: VGA_X = x0+dx, VGA_Y = y0+dy, VGA_COLOR = latched colour.
  - plot = 1 only if x0+dx < XSCREEN and y0+dy < YSCREEN. Compare at n+1 / n bits so there is no wrap-around.
  - Clipped pixels still take one cycle, with plot=0.
- Scan order is raster: dx increments each cycle. When dx==w-1, dx wraps to 0 and dy increments. When dx==w-1 and dy==h-1, go to FINISH.
- Latency:
  - start accepted at edge t: first pixel on the outputs after edge t+1, busy=1 from edge t.
  - Last pixel after edge t+w*h.
  - done=1 and busy=0 after edge t+w*h+1, with plot=0 in that cycle.
  - FINISH returns to IDLE after one cycle.
  - A new start can be accepted in the cycle done is high.
- Zero-size command: FINISH the cycle after acceptance (done after edge t+1); plot never asserts.
- Outputs hold their last value when plot=0. The adapter ignores them.
- Reset mid-draw: after the reset edge plot=0, busy=0, no done pulse, and the command is dropped.
- Counter widths: dx is n bits and dy is n-1 bits. Maximum is a full-screen rectangle, 160*120 = 19200 cycles at 160x120.

Decomposition:
- Shared package gift_pkg holds:
  - The resolution-derived constants n, XSCREEN, YSCREEN.
  - The state encoding (IDLE=2'd0, DRAW=2'd1, FINISH=2'd2).
  - The BG_DEFAULT colour constant.
- One natural sub-module: rect_scan_counter. It holds the dx/dy raster counter with clear, enable, and a last-pixel flag. The top level keeps the FSM, the latches and the clip/output registers.

Test Plan:
- Reset: assert Reset for 2 cycles mid-run -> busy=0, done=0, plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0.
- Basic fill: start with x0=10, y0=20, w=3, h=2, color=24'hFF0000, erase=0 -> six consecutive plot=1 cycles at (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), colour FF0000; done pulses exactly one cycle after the last pixel.
- Clipping: x0=158, y0=119, w=4, h=2 -> 8 busy cycles; plot=1 only at (158,119) and (159,119); done after 8 pixel cycles.
- Erase: x0=0, y0=0, w=2, h=1, color=24'h00FF00, erase=1, bg_color=24'h000000 -> two plots at (0,0) and (1,0) with VGA_COLOR=0.
- Zero size and ignored start: w=0 -> done the cycle after acceptance with no plot. During a 3x3 draw, pulse start with new coordinates -> exactly 9 pixels at the original coordinates, then done.
- Back-to-back and reset mid-draw:
  - Issue start in the done cycle -> the second command begins the next cycle.
  - Assert Reset on the 4th pixel of a 3x3 draw -> plot=0 next cycle, no done, and a following start draws normally.

Source files
------------

// File: rtl/gift_pkg.sv
// Shared constants and types for the falling-gifts rectangle raster engine.
// Screen geometry is derived from a single resolution string.
package gift_pkg;

  localparam logic [55:0] RESOLUTION = "160x120";

  localparam int n       = (RESOLUTION == "640x480") ? 10 :
                           (RESOLUTION == "320x240") ? 9  : 8;
  localparam int XSCREEN = (RESOLUTION == "640x480") ? 640 :
                           (RESOLUTION == "320x240") ? 320 : 160;
  localparam int YSCREEN = (RESOLUTION == "640x480") ? 480 :
                           (RESOLUTION == "320x240") ? 240 : 120;

  localparam logic [23:0] BG_DEFAULT = 24'h000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Sums are widened by one bit so a rectangle hanging off the right or
  // bottom edge is clipped instead of wrapping back onto the screen.
  function automatic logic on_screen(input logic [n-1:0] x0,
                                     input logic [n-1:0] dx,
                                     input logic [n-2:0] y0,
                                     input logic [n-2:0] dy);
    logic [n:0]   xs;
    logic [n-1:0] ys;
    xs = {1'b0, x0} + {1'b0, dx};
    ys = {1'b0, y0} + {1'b0, dy};
    return (xs < XSCREEN[n:0]) && (ys < YSCREEN[n-1:0]);
  endfunction

endpackage

// File: rtl/gift_rect_drawer_if.sv
// Command handshake plus VGA pixel-write bus of the rectangle drawer.
// start is sampled only while busy=0; done is a one-cycle pulse, and the pixel
// fields are meaningful only in cycles where plot=1.
interface gift_rect_drawer_if;
  import gift_pkg::*;

  logic           start;
  logic [n-1:0]   x0;
  logic [n-2:0]   y0;
  logic [n-1:0]   w;
  logic [n-2:0]   h;
  logic [23:0]    color;
  logic           erase;
  logic [23:0]    bg_color;
  logic           busy;
  logic           done;
  logic [n-1:0]   VGA_X;
  logic [n-2:0]   VGA_Y;
  logic [23:0]    VGA_COLOR;
  logic           plot;
  state_t         dbg_state;

  modport master (
    output start, x0, y0, w, h, color, erase, bg_color,
    input  busy, done, VGA_X, VGA_Y, VGA_COLOR, plot, dbg_state
  );

  modport slave (
    input  start, x0, y0, w, h, color, erase, bg_color,
    output busy, done, VGA_X, VGA_Y, VGA_COLOR, plot, dbg_state
  );

endinterface

// File: rtl/rect_scan_counter.sv
// Raster-order dx/dy counter for the rectangle drawer; last flags the final
// pixel of the current rectangle.
module rect_scan_counter
  import gift_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [n-1:0] w_last,
  input  logic [n-2:0] h_last,
  output logic [n-1:0] dx,
  output logic [n-2:0] dy,
  output logic         last
);

  assign last = (dx == w_last) && (dy == h_last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (dx == w_last) begin
        dx <= '0;
        dy <= dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gift_rect_drawer.sv
// Rectangle raster engine: latches one command, emits one pixel per clock in
// raster order with off-screen clipping, then pulses done.
module gift_rect_drawer
  import gift_pkg::*;
(
  input  logic CLOCK_50,
  input  logic Reset,
  gift_rect_drawer_if.slave bus
);

  state_t       state;
  logic [n-1:0] x0_q;
  logic [n-2:0] y0_q;
  logic [n-1:0] w_q;
  logic [n-2:0] h_q;
  logic [23:0]  col_q;

  logic [n-1:0] dx;
  logic [n-2:0] dy;
  logic         last;
  logic [n-1:0] w_last;
  logic [n-2:0] h_last;

  // Only consulted in DRAW, where both dimensions are known to be nonzero.
  assign w_last = w_q - 1'b1;
  assign h_last = h_q - 1'b1;

  assign bus.dbg_state = state;

  rect_scan_counter u_scan (
    .clk    (CLOCK_50),
    .rst    (Reset),
    .clr    (state != DRAW),
    .en     (state == DRAW),
    .w_last (w_last),
    .h_last (h_last),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.plot      <= 1'b0;
      bus.VGA_X     <= '0;
      bus.VGA_Y     <= '0;
      bus.VGA_COLOR <= '0;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      col_q         <= BG_DEFAULT;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.plot <= 1'b0;
          if (bus.start) begin
            x0_q     <= bus.x0;
            y0_q     <= bus.y0;
            w_q      <= bus.w;
            h_q      <= bus.h;
            col_q    <= bus.erase ? bus.bg_color : bus.color;
            bus.busy <= 1'b1;
            if (bus.w == '0 || bus.h == '0) state <= FINISH;
            else                            state <= DRAW;
          end
        end
        DRAW: begin
          bus.VGA_X     <= x0_q + dx;
          bus.VGA_Y     <= y0_q + dy;
          bus.VGA_COLOR <= col_q;
          bus.plot      <= on_screen(x0_q, dx, y0_q, dy);
          if (last) state <= FINISH;
        end
        FINISH: begin
          bus.plot <= 1'b0;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.plot <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gift_rect_drawer.sv
// Directed bench for gift_rect_drawer at 160x120: fills, clipping, erase,
// zero-size, ignored start, back-to-back and reset behaviour.
module tb_gift_rect_drawer;
  import gift_pkg::*;

  localparam int PW = 8 + 7 + 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  int            pc_q[$];

  gift_rect_drawer_if bus();

  gift_rect_drawer dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus.slave)
  );

  // clock / cycle counter / monitor
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.plot) begin
      got_q.push_back({bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR});
      pc_q.push_back(cyc);
    end
    if (!rst && bus.done) done_cnt = done_cnt + 1;
  end

  // driver tasks
  task automatic drive_cmd(input logic [7:0] x, input logic [6:0] y,
                           input logic [7:0] ww, input logic [6:0] hh,
                           input logic [23:0] col, input logic er,
                           input logic [23:0] bg);
    bus.x0 = x; bus.y0 = y; bus.w = ww; bus.h = hh;
    bus.color = col; bus.erase = er; bus.bg_color = bg;
    bus.start = 1'b1;
  endtask

  task automatic accept(output int t);
    @(posedge clk); #1;
    t = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) begin
        d = cyc;
        break;
      end
    end
  endtask

  task automatic run_cmd(input logic [7:0] x, input logic [6:0] y,
                         input logic [7:0] ww, input logic [6:0] hh,
                         input logic [23:0] col, input logic er,
                         input logic [23:0] bg, output int t, output int d);
    @(negedge clk);
    drive_cmd(x, y, ww, hh, col, er, bg);
    accept(t);
    wait_done(d);
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); pc_q.delete();
  endtask

  // tests
  task automatic test_reset();
    int t;
    total++;
    if ({bus.busy, bus.done, bus.plot} !== 3'b000 || bus.VGA_X !== 8'd0 ||
        bus.VGA_Y !== 7'd0 || bus.VGA_COLOR !== 24'd0 || bus.dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_init: busy=%b done=%b plot=%b x=%0d y=%0d c=%h st=%0d want all 0",
               bus.busy, bus.done, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_cmd(8'd5, 7'd5, 8'd5, 7'd5, 24'hABCDEF, 1'b0, 24'h0);
    accept(t);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.plot} !== 3'b000 || bus.VGA_X !== 8'd0 ||
        bus.VGA_Y !== 7'd0 || bus.VGA_COLOR !== 24'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b plot=%b x=%0d y=%0d c=%h want all 0",
               bus.busy, bus.done, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_fill();
    int t, d;
    clear_sb();
    exp_q.push_back({8'd10, 7'd20, 24'hFF0000});
    exp_q.push_back({8'd11, 7'd20, 24'hFF0000});
    exp_q.push_back({8'd12, 7'd20, 24'hFF0000});
    exp_q.push_back({8'd10, 7'd21, 24'hFF0000});
    exp_q.push_back({8'd11, 7'd21, 24'hFF0000});
    exp_q.push_back({8'd12, 7'd21, 24'hFF0000});
    run_cmd(8'd10, 7'd20, 8'd3, 7'd2, 24'hFF0000, 1'b0, 24'h123456, t, d);
    total++;
    if (got_q.size() != 6) begin
      bad++;
      $display("FAIL basic_count: got %0d pixels want 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || pc_q[i] != t + 1 + i) begin
        bad++;
        $display("FAIL basic_pix%0d: got %h at cyc %0d want %h at cyc %0d",
                 i, got_q[i], pc_q[i], exp_q[i], t + 1 + i);
      end
    end
    total++;
    if (d - t != 7) begin
      bad++;
      $display("FAIL basic_done_lat: got %0d want 7", d - t);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_clipping();
    int t, d;
    clear_sb();
    exp_q.push_back({8'd158, 7'd119, 24'h0000FF});
    exp_q.push_back({8'd159, 7'd119, 24'h0000FF});
    run_cmd(8'd158, 7'd119, 8'd4, 7'd2, 24'h0000FF, 1'b0, 24'h0, t, d);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL clip_count: got %0d pixels want 2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL clip_pix%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (d - t != 9) begin
      bad++;
      $display("FAIL clip_done_lat: got %0d want 9", d - t);
    end
  endtask

  task automatic test_erase();
    int t, d;
    clear_sb();
    exp_q.push_back({8'd0, 7'd0, 24'h000000});
    exp_q.push_back({8'd1, 7'd0, 24'h000000});
    run_cmd(8'd0, 7'd0, 8'd2, 7'd1, 24'h00FF00, 1'b1, 24'h000000, t, d);
    total++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      bad++;
      $display("FAIL erase_pix: got n=%0d first=%h want n=2 %h %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0], exp_q[1]);
    end
    total++;
    if (d - t != 3) begin
      bad++;
      $display("FAIL erase_done_lat: got %0d want 3", d - t);
    end
  endtask

  task automatic test_zero_size();
    int t, d;
    clear_sb();
    run_cmd(8'd30, 7'd30, 8'd0, 7'd5, 24'hFFFFFF, 1'b0, 24'h0, t, d);
    total++;
    if (d - t != 1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL zero_w: lat=%0d plots=%0d want 1 0", d - t, got_q.size());
    end
    run_cmd(8'd30, 7'd30, 8'd4, 7'd0, 24'hFFFFFF, 1'b0, 24'h0, t, d);
    total++;
    if (d - t != 1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL zero_h: lat=%0d plots=%0d want 1 0", d - t, got_q.size());
    end
  endtask

  task automatic test_ignored_start();
    int t, d;
    clear_sb();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        exp_q.push_back({8'(40 + c), 7'(50 + r), 24'h112233});
    @(negedge clk);
    drive_cmd(8'd40, 7'd50, 8'd3, 7'd3, 24'h112233, 1'b0, 24'h0);
    accept(t);
    @(negedge clk); @(negedge clk);
    drive_cmd(8'd90, 7'd90, 8'd2, 7'd2, 24'h445566, 1'b0, 24'h0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(d);
    total++;
    if (got_q.size() != 9 || d - t != 10) begin
      bad++;
      $display("FAIL ignore_count: plots=%0d lat=%0d want 9 10", got_q.size(), d - t);
    end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        total++;
        bad++;
        $display("FAIL ignore_pix%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_queued: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int t1, d1, t2, d2;
    clear_sb();
    run_cmd(8'd70, 7'd10, 8'd2, 7'd1, 24'hAAAAAA, 1'b0, 24'h0, t1, d1);
    drive_cmd(8'd80, 7'd11, 8'd1, 7'd2, 24'hBBBBBB, 1'b0, 24'h0);
    accept(t2);
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    wait_done(d2);
    total++;
    if (got_q.size() != 4 || d2 - t2 != 3) begin
      bad++;
      $display("FAIL b2b_count: plots=%0d lat=%0d want 4 3", got_q.size(), d2 - t2);
    end else begin
      total++;
      if (got_q[2] !== {8'd80, 7'd11, 24'hBBBBBB} || pc_q[2] != t2 + 1 ||
          got_q[3] !== {8'd80, 7'd12, 24'hBBBBBB}) begin
        bad++;
        $display("FAIL b2b_second: got %h@%0d %h want %h@%0d %h", got_q[2], pc_q[2],
                 got_q[3], {8'd80, 7'd11, 24'hBBBBBB}, t2 + 1, {8'd80, 7'd12, 24'hBBBBBB});
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    int t, d, dc;
    clear_sb();
    @(negedge clk);
    drive_cmd(8'd20, 7'd30, 8'd3, 7'd3, 24'hCCCCCC, 1'b0, 24'h0);
    accept(t);
    while (cyc < t + 4) @(negedge clk);
    total++;
    if (bus.plot !== 1'b1 || bus.VGA_X !== 8'd20 || bus.VGA_Y !== 7'd31) begin
      bad++;
      $display("FAIL rmid_4th: plot=%b x=%0d y=%0d want 1 20 31", bus.plot, bus.VGA_X, bus.VGA_Y);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.plot !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_after: plot=%b busy=%b want 0 0", bus.plot, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    dc = done_cnt;
    got_q.delete(); pc_q.delete();
    repeat (12) @(negedge clk);
    total++;
    if (done_cnt != dc || got_q.size() != 0) begin
      bad++;
      $display("FAIL rmid_dropped: done pulses=%0d plots=%0d want 0 0", done_cnt - dc, got_q.size());
    end
    run_cmd(8'd1, 7'd2, 8'd2, 7'd1, 24'hDDDDDD, 1'b0, 24'h0, t, d);
    total++;
    if (got_q.size() != 2 || got_q[0] !== {8'd1, 7'd2, 24'hDDDDDD} ||
        got_q[1] !== {8'd2, 7'd2, 24'hDDDDDD} || d - t != 3) begin
      bad++;
      $display("FAIL rmid_next: plots=%0d lat=%0d want 2 3", got_q.size(), d - t);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
    bus.color = '0; bus.erase = 1'b0; bus.bg_color = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_fill();
    test_clipping();
    test_erase();
    test_zero_size();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
